cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Instruction sequencer and architectural state for the embedded RISC core. Sits directly upstream of the ALU.
//  Owns PC, IR and ACC; drives the ALU's OpCode, CurrentState, ALUSrcA and ALUSrcB; writes ALU results back.
//  Runs the Init/InstrFetch/InstrExec cycle against a single ack-handshaked memory port.
//  Instruction word: IR[31:24] = opcode, IR[AddrWidth-1:0] = operand address/target.
// PARAMETERS
//  DataWidth   32  data, IR and ACC width
//  OpcodeSize  8   opcode field width (IR[31:24])
//  StateSize   2   CurrentState width
//  AddrWidth   24  PC width, memory address width and operand field width
// PORTS
//  clock       in   1          single clock, rising edge
//  reset       in   1          asynchronous, active-high
//  MemDataIn   in   DataWidth  memory read data, valid when MemAck=1
//  MemAck      in   1          memory transfer complete this cycle
//  ALUDataOut  in   DataWidth  ALU result (combinational from ALUSrcA/ALUSrcB/OpCode/CurrentState)
//  ALUSrcA     out  DataWidth  always ACC
//  ALUSrcB     out  DataWidth  PC, MemDataIn, zero-extended operand, or ACC (see BEHAVIOUR)
//  OpCode      out  OpcodeSize IR[31:24]
//  CurrentState out StateSize  00 Init, 01 InstrFetch, 10 InstrExec, 11 Halt
//  MemAddr     out  AddrWidth  PC in fetch, operand in exec
//  MemDataOut  out  DataWidth  ACC (meaningful only while MemWr=1)
//  MemRd       out  1          read request
//  MemWr       out  1          write request
//  Halted      out  1          high in Halt state
//  PCOut       out  AddrWidth  current PC (debug)
//  AccOut      out  DataWidth  current ACC (debug)
// BEHAVIOUR
//  Reset (async, immediate): state=Init, PC=0, ACC=0, IR=32'h0F00_0000 (NOP), so OpCode=8'h0F.
//   MemRd=0, MemWr=0, Halted=0. Any in-flight request is dropped.
//  MemRd/MemWr/MemAddr/ALUSrcB are combinational decodes of state and IR.
//   MemAck in the first request cycle completes it (zero-wait).
//   Otherwise request, address and write data are held stable until MemAck=1. MemAck with no request is ignored.
//  Init: one cycle, then InstrFetch.
//  InstrFetch: MemRd=1, MemAddr=PC, ALUSrcB=PC (ALU returns PC+1).
//   On MemAck: IR<=MemDataIn, PC<=ALUDataOut[AddrWidth-1:0], next state InstrExec.
//  InstrExec, memory opcodes (hold until MemAck, then InstrFetch):
//   LDA 00: MemRd at operand, ALUSrcB=MemDataIn, ACC<=ALUDataOut.
//   ADD 02, SUB 03, AND 0A, OR 0B, XOR 0C: same, ACC<=ALUDataOut (ACC op mem).
//   STO 01: MemWr at operand, MemDataOut=ACC; ACC unchanged.
//  InstrExec, single-cycle opcodes (always one cycle, then InstrFetch):
//   SHR 08, SHL 09, COM 0D, SWP 0E: ALUSrcB=ACC, ACC<=ALUDataOut.
//   JMP 04: ALUSrcB=operand (zero-extended), PC<=operand.
//   JGE 05: PC<=operand iff ACC[DataWidth-1]==0, else PC unchanged.
//   JNE 06: PC<=operand iff ACC!=0, else PC unchanged.
//   NOP 0F and undefined opcodes (10..FF, incl. MAP 64): no state change.
//  STP 07: next state Halt; Halted=1. PC/ACC/IR frozen, MemRd=MemWr=0. Only reset leaves Halt.
//  Arithmetic: PC wraps modulo 2^AddrWidth (0xFFFFFF fetch -> PC=0). ACC add/sub wrap modulo 2^DataWidth, no flags.
//  Throughput: minimum 2 cycles/instruction (fetch + exec), plus memory wait cycles.
// TESTING
//  1 reset release -> Init 1 cycle, then state=01, MemRd=1, MemAddr=0, OpCode=0F.
//  2 mem[0]=LDA 10, mem[1]=ADD 11, mem[2]=STO 12, mem[10]=5, mem[11]=7, zero-wait
//     -> MemWr at 0x12 with MemDataOut=12; PC=3 after STO; 6 cycles from first fetch.
//  3 fetch with MemAck delayed 3 cycles -> MemRd, MemAddr held for 4 cycles; IR and PC unchanged until ack.
//  4 JNE 0x40 with ACC=0 -> next fetch at PC+1; with ACC=1 -> next fetch at 0x40.
//     JGE with ACC=0x8000_0000 -> not taken.
//  5 ACC=0x1234_5678: SWP -> 0x5678_1234; COM -> 0xA987_EDCB; SHL -> 0x2468_ACF0.
//  6 STP -> state=11, Halted=1, no MemRd/MemWr for 20 cycles.
//     Assert reset mid-LDA wait -> outputs at reset values the same cycle; refetch from 0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Instruction sequencer for the embedded RISC core: owns PC/IR/ACC, runs the
// fetch/execute cycle over a single ack-handshaked memory port and steers the ALU.
module cpu_sequencer #(
    parameter int DataWidth  = 32,
    parameter int OpcodeSize = 8,
    parameter int StateSize  = 2,
    parameter int AddrWidth  = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DataWidth-1:0]  MemDataIn,
    input  logic                  MemAck,
    input  logic [DataWidth-1:0]  ALUDataOut,
    output logic [DataWidth-1:0]  ALUSrcA,
    output logic [DataWidth-1:0]  ALUSrcB,
    output logic [OpcodeSize-1:0] OpCode,
    output logic [StateSize-1:0]  CurrentState,
    output logic [AddrWidth-1:0]  MemAddr,
    output logic [DataWidth-1:0]  MemDataOut,
    output logic                  MemRd,
    output logic                  MemWr,
    output logic                  Halted,
    output logic [AddrWidth-1:0]  PCOut,
    output logic [DataWidth-1:0]  AccOut
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [OpcodeSize-1:0] OP_LDA = OpcodeSize'(8'h00);
    localparam logic [OpcodeSize-1:0] OP_STO = OpcodeSize'(8'h01);
    localparam logic [OpcodeSize-1:0] OP_ADD = OpcodeSize'(8'h02);
    localparam logic [OpcodeSize-1:0] OP_SUB = OpcodeSize'(8'h03);
    localparam logic [OpcodeSize-1:0] OP_JMP = OpcodeSize'(8'h04);
    localparam logic [OpcodeSize-1:0] OP_JGE = OpcodeSize'(8'h05);
    localparam logic [OpcodeSize-1:0] OP_JNE = OpcodeSize'(8'h06);
    localparam logic [OpcodeSize-1:0] OP_STP = OpcodeSize'(8'h07);
    localparam logic [OpcodeSize-1:0] OP_SHR = OpcodeSize'(8'h08);
    localparam logic [OpcodeSize-1:0] OP_SHL = OpcodeSize'(8'h09);
    localparam logic [OpcodeSize-1:0] OP_AND = OpcodeSize'(8'h0A);
    localparam logic [OpcodeSize-1:0] OP_OR  = OpcodeSize'(8'h0B);
    localparam logic [OpcodeSize-1:0] OP_XOR = OpcodeSize'(8'h0C);
    localparam logic [OpcodeSize-1:0] OP_COM = OpcodeSize'(8'h0D);
    localparam logic [OpcodeSize-1:0] OP_SWP = OpcodeSize'(8'h0E);
    localparam logic [OpcodeSize-1:0] OP_NOP = OpcodeSize'(8'h0F);

    localparam logic [DataWidth-1:0] NOP_IR = {OP_NOP, {(DataWidth-OpcodeSize){1'b0}}};

    state_t                 state_r;
    state_t                 state_next_s;
    logic [AddrWidth-1:0]   pc_r;
    logic [AddrWidth-1:0]   pc_next_s;
    logic [DataWidth-1:0]   acc_r;
    logic [DataWidth-1:0]   acc_next_s;
    logic [DataWidth-1:0]   ir_r;
    logic [DataWidth-1:0]   ir_next_s;
    logic [OpcodeSize-1:0]  opcode_s;
    logic [AddrWidth-1:0]   operand_s;
    logic [DataWidth-1:0]   operand_ext_s;
    logic [DataWidth-1:0]   pc_ext_s;
    logic                   mem_rd_s;
    logic                   mem_wr_s;
    logic [AddrWidth-1:0]   mem_addr_s;
    logic [DataWidth-1:0]   alu_src_b_s;

    // Opcodes that read an operand from memory and load the ALU result into ACC.
    function automatic logic is_mem_read_op(input logic [OpcodeSize-1:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
    endfunction

    function automatic logic is_acc_op(input logic [OpcodeSize-1:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_COM) || (op == OP_SWP);
    endfunction

    function automatic logic is_jump_op(input logic [OpcodeSize-1:0] op);
        return (op == OP_JMP) || (op == OP_JGE) || (op == OP_JNE);
    endfunction

    assign opcode_s      = ir_r[DataWidth-1 -: OpcodeSize];
    assign operand_s     = ir_r[AddrWidth-1:0];
    assign operand_ext_s = {{(DataWidth-AddrWidth){1'b0}}, operand_s};
    assign pc_ext_s      = {{(DataWidth-AddrWidth){1'b0}}, pc_r};

    // Memory request and ALU operand steering, decoded from state and IR only.
    always_comb begin
        mem_rd_s    = 1'b0;
        mem_wr_s    = 1'b0;
        mem_addr_s  = pc_r;
        alu_src_b_s = pc_ext_s;
        case (state_r)
            ST_FETCH: begin
                mem_rd_s    = 1'b1;
                mem_addr_s  = pc_r;
                alu_src_b_s = pc_ext_s;
            end
            ST_EXEC: begin
                mem_addr_s = operand_s;
                if (is_mem_read_op(opcode_s)) begin
                    mem_rd_s    = 1'b1;
                    alu_src_b_s = MemDataIn;
                end else if (opcode_s == OP_STO) begin
                    mem_wr_s    = 1'b1;
                    alu_src_b_s = acc_r;
                end else if (is_acc_op(opcode_s)) begin
                    alu_src_b_s = acc_r;
                end else if (is_jump_op(opcode_s)) begin
                    alu_src_b_s = operand_ext_s;
                end else begin
                    alu_src_b_s = pc_ext_s;
                end
            end
            default: begin
                mem_rd_s    = 1'b0;
                mem_wr_s    = 1'b0;
            end
        endcase
    end

    // Next-state and architectural-register update rules.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        acc_next_s   = acc_r;
        ir_next_s    = ir_r;
        case (state_r)
            ST_INIT: state_next_s = ST_FETCH;
            ST_FETCH: begin
                if (MemAck) begin
                    ir_next_s    = MemDataIn;
                    pc_next_s    = ALUDataOut[AddrWidth-1:0];
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                state_next_s = ST_FETCH;
                if (is_mem_read_op(opcode_s)) begin
                    if (MemAck) begin
                        acc_next_s = ALUDataOut;
                    end else begin
                        state_next_s = ST_EXEC;
                    end
                end else if (opcode_s == OP_STO) begin
                    if (MemAck) begin
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_EXEC;
                    end
                end else if (is_acc_op(opcode_s)) begin
                    acc_next_s = ALUDataOut;
                end else begin
                    case (opcode_s)
                        OP_JMP: pc_next_s = operand_s;
                        OP_JGE: begin
                            if (!acc_r[DataWidth-1]) begin
                                pc_next_s = operand_s;
                            end else begin
                                pc_next_s = pc_r;
                            end
                        end
                        OP_JNE: begin
                            if (acc_r != {DataWidth{1'b0}}) begin
                                pc_next_s = operand_s;
                            end else begin
                                pc_next_s = pc_r;
                            end
                        end
                        OP_STP:  state_next_s = ST_HALT;
                        default: pc_next_s = pc_r;
                    endcase
                end
            end
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_INIT;
        endcase
    end

    // Architectural state registers; reset drops any in-flight request at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_INIT;
            pc_r    <= {AddrWidth{1'b0}};
            acc_r   <= {DataWidth{1'b0}};
            ir_r    <= NOP_IR;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            acc_r   <= acc_next_s;
            ir_r    <= ir_next_s;
        end
    end

    assign ALUSrcA      = acc_r;
    assign ALUSrcB      = alu_src_b_s;
    assign OpCode       = opcode_s;
    assign CurrentState = StateSize'(state_r);
    assign MemAddr      = mem_addr_s;
    assign MemDataOut   = acc_r;
    assign MemRd        = mem_rd_s;
    assign MemWr        = mem_wr_s;
    assign Halted       = (state_r == ST_HALT);
    assign PCOut        = pc_r;
    assign AccOut       = acc_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a memory/ALU environment plus an ISA-level
// reference model compared every cycle, and literal expectations for key points.
module tb_cpu_sequencer;

    logic        clock;
    logic        reset;
    logic [31:0] MemDataIn;
    logic        MemAck;
    logic [31:0] ALUDataOut;
    logic [31:0] ALUSrcA;
    logic [31:0] ALUSrcB;
    logic [7:0]  OpCode;
    logic [1:0]  CurrentState;
    logic [23:0] MemAddr;
    logic [31:0] MemDataOut;
    logic        MemRd;
    logic        MemWr;
    logic        Halted;
    logic [23:0] PCOut;
    logic [31:0] AccOut;

    cpu_sequencer dut (
        .clock(clock), .reset(reset), .MemDataIn(MemDataIn), .MemAck(MemAck),
        .ALUDataOut(ALUDataOut), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .OpCode(OpCode), .CurrentState(CurrentState), .MemAddr(MemAddr),
        .MemDataOut(MemDataOut), .MemRd(MemRd), .MemWr(MemWr), .Halted(Halted),
        .PCOut(PCOut), .AccOut(AccOut)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:4095];
    int          ack_wait;
    logic        stray_ack;
    int          req_cnt;
    logic        cap_req, cap_wr;
    logic [23:0] cap_addr;
    logic [31:0] cap_wdata;

    // reference model: architectural view
    int          m_phase;
    logic [23:0] m_pc;
    logic [31:0] m_acc;
    logic [31:0] m_ir;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ALU environment: fetch increments operand B, execute applies the opcode.
    always_comb begin
        ALUDataOut = ALUSrcB;
        if (CurrentState == 2'b01) begin
            ALUDataOut = ALUSrcB + 32'd1;
        end else begin
            case (OpCode)
                8'h02:   ALUDataOut = ALUSrcA + ALUSrcB;
                8'h03:   ALUDataOut = ALUSrcA - ALUSrcB;
                8'h0A:   ALUDataOut = ALUSrcA & ALUSrcB;
                8'h0B:   ALUDataOut = ALUSrcA | ALUSrcB;
                8'h0C:   ALUDataOut = ALUSrcA ^ ALUSrcB;
                8'h08:   ALUDataOut = ALUSrcA >> 1;
                8'h09:   ALUDataOut = ALUSrcA << 1;
                8'h0D:   ALUDataOut = ~ALUSrcA;
                8'h0E:   ALUDataOut = {ALUSrcA[15:0], ALUSrcA[31:16]};
                default: ALUDataOut = ALUSrcB;
            endcase
        end
    end

    function automatic logic [31:0] rd_mem(input logic [23:0] a);
        return mem[a[11:0]];
    endfunction

    function automatic logic is_memop(input logic [7:0] op);
        return op inside {8'h00, 8'h02, 8'h03, 8'h0A, 8'h0B, 8'h0C};
    endfunction

    function automatic logic is_accop(input logic [7:0] op);
        return op inside {8'h08, 8'h09, 8'h0D, 8'h0E};
    endfunction

    // ISA meaning of each ACC-writing instruction, independent of the ALU port.
    function automatic logic [31:0] isa_acc(input logic [7:0] op, input logic [31:0] acc,
                                            input logic [31:0] m);
        case (op)
            8'h00:   return m;
            8'h02:   return acc + m;
            8'h03:   return acc - m;
            8'h0A:   return acc & m;
            8'h0B:   return acc | m;
            8'h0C:   return acc ^ m;
            8'h08:   return {1'b0, acc[31:1]};
            8'h09:   return {acc[30:0], 1'b0};
            8'h0D:   return ~acc;
            8'h0E:   return {acc[15:0], acc[31:16]};
            default: return acc;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = 24'h0;
        m_acc   = 32'h0;
        m_ir    = 32'h0F00_0000;
    endtask

    // One clock of the instruction cycle, given whether memory acknowledged.
    task automatic model_step(input logic ack);
        logic [7:0]  op;
        logic [23:0] opd;
        op  = m_ir[31:24];
        opd = m_ir[23:0];
        case (m_phase)
            0: m_phase = 1;
            1: if (ack) begin
                   m_ir    = rd_mem(m_pc);
                   m_pc    = m_pc + 24'd1;
                   m_phase = 2;
               end
            2: begin
                if (is_memop(op)) begin
                    if (ack) begin
                        m_acc   = isa_acc(op, m_acc, rd_mem(opd));
                        m_phase = 1;
                    end
                end else if (op == 8'h01) begin
                    if (ack) m_phase = 1;
                end else if (is_accop(op)) begin
                    m_acc   = isa_acc(op, m_acc, 32'h0);
                    m_phase = 1;
                end else if (op == 8'h07) begin
                    m_phase = 3;
                end else begin
                    if (op == 8'h04) m_pc = opd;
                    if (op == 8'h05 && !m_acc[31]) m_pc = opd;
                    if (op == 8'h06 && m_acc != 32'h0) m_pc = opd;
                    m_phase = 1;
                end
            end
            default: m_phase = 3;
        endcase
    endtask

    // Environment + per-cycle compare: advance model for the edge just past,
    // serve memory, drive the next ack, then compare DUT against the model.
    initial begin
        logic [7:0]  op;
        logic [23:0] opd;
        logic        e_rd, e_wr;
        req_cnt = 0; cap_req = 1'b0; cap_wr = 1'b0; cap_addr = 24'h0; cap_wdata = 32'h0;
        model_reset();
        forever begin
            @(negedge clock);
            if (reset) begin
                model_reset();
                req_cnt = 0; cap_req = 1'b0; cap_wr = 1'b0;
                MemAck  = 1'b0;
            end else begin
                model_step(MemAck);
                if (cap_wr && MemAck) mem[cap_addr[11:0]] = cap_wdata;
                req_cnt   = (cap_req && !MemAck) ? req_cnt + 1 : 0;
                cap_req   = MemRd | MemWr;
                cap_wr    = MemWr;
                cap_addr  = MemAddr;
                cap_wdata = MemDataOut;
                MemDataIn = rd_mem(MemAddr);
                MemAck    = cap_req ? (req_cnt >= ack_wait) : stray_ack;
                #1;
                op   = m_ir[31:24];
                opd  = m_ir[23:0];
                e_rd = (m_phase == 1) || (m_phase == 2 && is_memop(op));
                e_wr = (m_phase == 2) && (op == 8'h01);
                chk("state",  {30'h0, CurrentState}, 32'(m_phase));
                chk("halted", {31'h0, Halted}, {31'h0, m_phase == 3});
                chk("opcode", {24'h0, OpCode}, {24'h0, op});
                chk("pc",     {8'h0, PCOut}, {8'h0, m_pc});
                chk("acc",    AccOut, m_acc);
                chk("srca",   ALUSrcA, m_acc);
                chk("memrd",  {31'h0, MemRd}, {31'h0, e_rd});
                chk("memwr",  {31'h0, MemWr}, {31'h0, e_wr});
                if (e_rd || e_wr) chk("memaddr", {8'h0, MemAddr}, {8'h0, (m_phase == 1) ? m_pc : opd});
                if (e_wr) chk("wdata", MemDataOut, m_acc);
                if (m_phase == 1) chk("srcb_pc", ALUSrcB, {8'h0, m_pc});
                if (m_phase == 2 && is_memop(op)) chk("srcb_mem", ALUSrcB, rd_mem(opd));
                if (m_phase == 2 && is_accop(op)) chk("srcb_acc", ALUSrcB, m_acc);
                if (m_phase == 2 && op inside {8'h04, 8'h05, 8'h06}) chk("srcb_opd", ALUSrcB, {8'h0, opd});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #2;
    endtask

    task automatic begin_prog(input int w, input logic stray);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0700_0000;
        ack_wait  = w;
        stray_ack = stray;
    endtask

    task automatic release_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int rdwr;
        reset = 1'b1; MemAck = 1'b0; MemDataIn = 32'h0; ack_wait = 0; stray_ack = 1'b0;

        // LDA/ADD/STO zero-wait, then halt with stray acks
        begin_prog(0, 1'b0);
        mem[0] = 32'h0000_0010; mem[1] = 32'h0200_0011; mem[2] = 32'h0100_0012;
        mem[3] = 32'h0700_0000; mem[16] = 32'd5; mem[17] = 32'd7;
        #1;
        chk("rst_state", {30'h0, CurrentState}, 32'h0);
        chk("rst_opcode", {24'h0, OpCode}, 32'h0F);
        chk("rst_memrd", {31'h0, MemRd}, 32'h0);
        release_reset();
        step(1);
        chk("t1_state", {30'h0, CurrentState}, 32'h1);
        chk("t1_memrd", {31'h0, MemRd}, 32'h1);
        chk("t1_addr", {8'h0, MemAddr}, 32'h0);
        chk("t1_opcode", {24'h0, OpCode}, 32'h0F);
        step(5);
        chk("sto_wr", {31'h0, MemWr}, 32'h1);
        chk("sto_addr", {8'h0, MemAddr}, 32'h12);
        chk("sto_data", MemDataOut, 32'd12);
        chk("sto_pc", {8'h0, PCOut}, 32'h3);
        step(3);
        chk("stp_state", {30'h0, CurrentState}, 32'h3);
        chk("stp_halted", {31'h0, Halted}, 32'h1);
        chk("sto_mem", mem[18], 32'd12);
        stray_ack = 1'b1;
        rdwr = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (MemRd || MemWr) rdwr++;
        end
        chk("halt_no_mem", 32'(rdwr), 32'h0);
        chk("halt_pc", {8'h0, PCOut}, 32'h4);

        // fetch and LDA with 3 wait cycles, then reset mid-LDA wait
        begin_prog(3, 1'b0);
        mem[0] = 32'h0000_0020; mem[32] = 32'h1234_5678;
        release_reset();
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("wait_rd", {31'h0, MemRd}, 32'h1);
            chk("wait_addr", {8'h0, MemAddr}, 32'h0);
            chk("wait_pc", {8'h0, PCOut}, 32'h0);
            chk("wait_ir", {24'h0, OpCode}, 32'h0F);
        end
        step(1);
        chk("wait_exec", {30'h0, CurrentState}, 32'h2);
        chk("wait_pc1", {8'h0, PCOut}, 32'h1);
        step(1);
        reset = 1'b1;
        #1;
        chk("arst_state", {30'h0, CurrentState}, 32'h0);
        chk("arst_rd", {30'h0, MemRd, MemWr}, 32'h0);
        chk("arst_pc", {8'h0, PCOut}, 32'h0);
        chk("arst_opcode", {24'h0, OpCode}, 32'h0F);
        chk("arst_halted", {31'h0, Halted}, 32'h0);
        ack_wait = 0;
        release_reset();
        step(1);
        chk("refetch_addr", {8'h0, MemAddr}, 32'h0);
        chk("refetch_rd", {31'h0, MemRd}, 32'h1);
        step(2);
        chk("refetch_acc", AccOut, 32'h1234_5678);

        // conditional jumps, JMP to top of address space and PC wrap
        begin_prog(0, 1'b0);
        mem[0] = 32'h0600_0040; mem[1] = 32'h0000_0030; mem[2] = 32'h0600_0040;
        mem[48] = 32'h1; mem[64] = 32'h0000_0031; mem[49] = 32'h8000_0000;
        mem[65] = 32'h0500_0050; mem[66] = 32'h04FF_FFFF; mem[4095] = 32'h6400_0000;
        release_reset();
        step(3);
        chk("jne_nt", {8'h0, MemAddr}, 32'h1);
        step(4);
        chk("jne_t", {8'h0, MemAddr}, 32'h40);
        step(4);
        chk("jge_nt", {8'h0, MemAddr}, 32'h42);
        step(1);
        chk("jmp_srcb", ALUSrcB, 32'h00FF_FFFF);
        step(1);
        chk("jmp_addr", {8'h0, MemAddr}, 32'h00FF_FFFF);
        step(1);
        chk("wrap_pc", {8'h0, PCOut}, 32'h0);
        chk("map_op", {24'h0, OpCode}, 32'h64);
        step(1);
        chk("map_acc", AccOut, 32'h8000_0000);

        // SWP/COM/SHL on a known ACC
        begin_prog(0, 1'b0);
        mem[0] = 32'h0000_0020; mem[1] = 32'h0E00_0000; mem[2] = 32'h0D00_0000;
        mem[3] = 32'h0000_0020; mem[4] = 32'h0900_0000; mem[32] = 32'h1234_5678;
        release_reset();
        step(5);
        chk("swp", AccOut, 32'h5678_1234);
        step(2);
        chk("com", AccOut, 32'hA987_EDCB);
        step(4);
        chk("shl", AccOut, 32'h2468_ACF0);

        // ALU mix with one wait cycle and stray acks on non-memory cycles
        begin_prog(1, 1'b1);
        mem[0] = 32'h0000_0020; mem[1] = 32'h0300_0021; mem[2] = 32'h0A00_0022;
        mem[3] = 32'h0B00_0023; mem[4] = 32'h0C00_0024; mem[5] = 32'h0800_0000;
        mem[6] = 32'h0100_0025; mem[7] = 32'h0F00_0000; mem[8] = 32'h0200_0026;
        mem[32] = 32'h1234_5678; mem[33] = 32'h2000_0000; mem[34] = 32'hFF00_FF00;
        mem[35] = 32'h0000_000F; mem[36] = 32'hFFFF_FFFF; mem[37] = 32'h0; mem[38] = 32'hFFFF_FFFF;
        release_reset();
        step(45);
        chk("mix_halted", {31'h0, Halted}, 32'h1);
        chk("mix_store", mem[37], 32'h06FF_D4F8);
        chk("mix_acc", AccOut, 32'h06FF_D4F7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
